// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed hex seven-segment display back-end
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] showdata,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [1:0]  src_sel,
    input  logic        blank_en,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      snap;
    logic [31:0]      src_word;
    logic [31:0]      snap_hi;
    logic [3:0]       nib;
    logic             tick;
    logic             reload;
    logic             digit_blank;
    logic [6:0]       hex_seg;

    assign tick   = (cnt == CNT_LAST);
    assign reload = tick && (idx == 3'd7) && !freeze;

    // Source selection for the next snapshot
    always_comb begin
        src_word = 32'h0;
        case (src_sel)
            2'd0:    src_word = showdata;
            2'd1:    src_word = pc;
            2'd2:    src_word = inst;
            default: src_word = 32'h0;
        endcase
    end

    // Per-digit dwell counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index advance and once-per-frame snapshot at the 7->0 wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= 3'd0;
            snap       <= 32'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= reload;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            if (reload) begin
                snap <= src_word;
            end
        end
    end

    // Current digit nibble and leading-zero detection on the bits at and above it
    always_comb begin
        snap_hi     = snap >> {idx, 2'b00};
        nib         = snap_hi[3:0];
        digit_blank = blank_en && (idx != 3'd0) && (snap_hi == 32'h0);
    end

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}
    always_comb begin
        hex_seg = 7'h7F;
        case (nib)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    end

    // Registered drive to the display pins; only one digit enable low at a time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= digit_blank ? 8'hFF : ~(8'b1 << idx);
            seg <= digit_blank ? 7'h7F : hex_seg;
            dp  <= !((idx == 3'd0) && freeze);
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display
module tb_seg7_scan_display;

    localparam int SD = 4;
    localparam int FR = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] showdata = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] inst = 32'h0;
    logic [1:0]  src_sel = 2'd0;
    logic        blank_en = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_pass = 0;
    int n_total = 0;

    int          e = 0;
    logic        ft_flag = 1'b0;
    logic        frz_e = 1'b0;
    logic        blk_e = 1'b0;
    logic [31:0] cur_snap = 32'h0;
    logic [31:0] exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_display #(.SCAN_DIV(SD), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .showdata(showdata), .pc(pc), .inst(inst),
        .src_sel(src_sel), .blank_en(blank_en), .freeze(freeze),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s);
        if (s == 2'd0) return showdata;
        if (s == 2'd1) return pc;
        if (s == 2'd2) return inst;
        return 32'h0;
    endfunction

    // Expected {an, seg, dp} for digit i of word s
    function automatic logic [15:0] disp(input logic [31:0] s, input int i,
                                         input logic b, input logic f);
        logic [31:0] hi;
        logic        blank;
        logic [7:0]  a;
        logic [6:0]  sg;
        hi    = s >> (4 * i);
        blank = b && (i != 0) && (hi == 0);
        a     = blank ? 8'hFF : 8'(255 - (1 << i));
        sg    = blank ? 7'h7F : hex_tab[hi % 16];
        return {a, sg, !((i == 0) && f)};
    endfunction

    // Reference timeline: count edges since reset, push a snapshot at every unfrozen frame wrap
    always @(posedge clk) begin
        if (!rst) begin
            e = 0;
            ft_flag = 1'b0;
            exp_q.delete();
        end else begin
            e++;
            frz_e = freeze;
            blk_e = blank_en;
            ft_flag = 1'b0;
            if ((e % FR) == 0 && !freeze) begin
                exp_q.push_back(pick(src_sel));
                ft_flag = 1'b1;
            end
        end
    end

    // Monitor: checks every displayed cycle, pops a snapshot whenever the DUT pulses frame_tick
    always @(negedge clk) begin
        if (!rst) begin
            cur_snap = 32'h0;
        end else if (e > 0) begin
            chk("frame_tick", 32'(frame_tick), 32'(ft_flag));
            chk("display", {16'h0, an, seg, dp},
                {16'h0, disp(cur_snap, ((e - 1) / SD) % 8, blk_e, frz_e)});
            if (frame_tick) begin
                if (exp_q.size() == 0) chk("unexpected_tick", 32'd1, 32'd0);
                else cur_snap = exp_q.pop_front();
            end
        end
    end

    function automatic logic [31:0] rnd_word();
        return $urandom >> $urandom_range(0, 31);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cycles(2);
        chk("reset_an", 32'(an), 32'hFF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_ft", 32'(frame_tick), 32'h0);
        showdata = 32'h1234ABCD;
        rst = 1'b1;
        cycles(2 * FR);

        src_sel = 2'd1; pc = 32'h00000040; blank_en = 1'b1;
        cycles(2 * FR);
        blank_en = 1'b0;
        cycles(FR);

        cycles(5);
        freeze = 1'b1;
        showdata = 32'hFFFFFFFF; src_sel = 2'd0;
        cycles(2 * FR);
        freeze = 1'b0;
        cycles(2 * FR);

        for (int k = 0; k < 4 * FR && !((((e / SD) % 8) == 5) && ((e % SD) == 1)); k++)
            @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hFF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_ft", 32'(frame_tick), 32'h0);
        cycles(3);
        showdata = 32'h00C0FFEE; inst = 32'hDEADBEEF; src_sel = 2'd0;
        rst = 1'b1;
        cycles(FR + 3 * SD);
        src_sel = 2'd2;
        cycles(2 * FR);

        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < FR; c++) begin
                showdata = rnd_word();
                pc = rnd_word();
                inst = rnd_word();
                if ($urandom_range(0, 15) == 0) src_sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
                if ($urandom_range(0, 31) == 0) freeze = ~freeze;
                @(negedge clk);
            end
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
